can_bit_destuffer: RTL and testbench

- Sits directly downstream of the bit-synchronisation unit.
- Collects the per-bit sample strobes and resolves each CAN bit, by single sample or 3-sample majority.
- Detects bus idle and start-of-frame, removes stuff bits, and flags stuff errors.
- Delivers a clean destuffed bit stream, one valid pulse per data bit, to the frame decoder.

---
 rtl/can_bit_destuffer_pkg.sv | 22 ++
 rtl/can_bit_destuffer_bit_voter.sv | 62 ++++++
 rtl/can_bit_destuffer.sv | 133 +++++++++++++
 tb/tb_can_bit_destuffer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/can_bit_destuffer_pkg.sv
// Shared types and constants for the CAN bit destuffer: FSM states, bus
// levels, default timing parameters and the 3-sample majority function.
package can_bit_destuffer_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        FRAME,
        ERROR
    } destufState_t;

    localparam logic CAN_RECESSIVE = 1'b1;
    localparam logic CAN_DOMINANT  = 1'b0;

    localparam int DEFAULT_IDLE_BITS = 11;
    localparam int DEFAULT_STUFF_LEN = 5;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/can_bit_destuffer_bit_voter.sv
// Collects sample strobes within a bit period and resolves the bit at
// bitStrobe, by single sample or 3-sample majority, flagging missing samples.
module bit_voter
    import can_bit_destuffer_pkg::*;
(
    input  logic clk,
    input  logic resetN,
    input  logic sampleIn,
    input  logic samplePulse,
    input  logic bitStrobe,
    input  logic multiSelect,
    output logic resolvedBit,
    output logic resolveStrobe,
    output logic missStrobe
);

    logic [2:0] smp;
    logic [2:0] smpEff;
    logic [1:0] sampleCnt;
    logic [1:0] cntEff;
    logic       prevBit;

    // A sample arriving on the bitStrobe cycle already belongs to this bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        smpEff        = samplePulse ? {smp[1:0], sampleIn} : smp;
        cntEff        = (samplePulse && sampleCnt != 2'd3) ? sampleCnt + 2'd1 : sampleCnt;
        resolveStrobe = bitStrobe;
        resolvedBit   = prevBit;
        missStrobe    = 1'b0;
        if (multiSelect) begin
            if (cntEff == 2'd3) begin
                resolvedBit = majority3(smpEff);
            end else begin
                missStrobe = bitStrobe;
                if (cntEff != 2'd0) resolvedBit = smpEff[0];
            end
        end else begin
            if (cntEff != 2'd0) resolvedBit = smpEff[0];
            else                missStrobe  = bitStrobe;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; the small
        // sample window is reset to recessive so an early vote cannot read X.
        if (!resetN) begin
            smp       <= 3'b111;
            sampleCnt <= 2'd0;
            prevBit   <= CAN_RECESSIVE;
        end else begin
            if (samplePulse) smp <= smpEff;
            if (bitStrobe) begin
                sampleCnt <= 2'd0;
                prevBit   <= resolvedBit;
            end else begin
                sampleCnt <= cntEff;
            end
        end
    end

endmodule

// File: rtl/can_bit_destuffer.sv
// CAN bit destuffer: resolves bits, tracks bus idle and start of frame,
// removes stuff bits and flags stuff violations, all outputs registered.
module can_bit_destuffer
    import can_bit_destuffer_pkg::*;
#(
    parameter int IDLE_BITS = DEFAULT_IDLE_BITS,
    parameter int STUFF_LEN = DEFAULT_STUFF_LEN
) (
    input  logic clk,
    input  logic resetN,
    input  logic sampleIn,
    input  logic samplePulse,
    input  logic bitStrobe,
    input  logic multiSelect,
    input  logic enable,
    output logic bitOut,
    output logic bitValid,
    output logic sof,
    output logic stuffErr,
    output logic sampleMiss,
    output logic busIdle
);

    localparam logic [3:0] IDLE_CNT  = 4'(IDLE_BITS);
    localparam logic [2:0] STUFF_CNT = 3'(STUFF_LEN);

    logic         rBit, rStrobe, rMiss;
    destufState_t state, stateNext;
    logic [3:0]   recCnt, recCntNext, recInc;
    logic [2:0]   runLen, runLenNext;
    logic         runVal, runValNext;
    logic         bitOutNext, bitValidNext, sofNext, stuffErrNext;

    bit_voter uVoter (
        .clk          (clk),
        .resetN       (resetN),
        .sampleIn     (sampleIn),
        .samplePulse  (samplePulse),
        .bitStrobe    (bitStrobe),
        .multiSelect  (multiSelect),
        .resolvedBit  (rBit),
        .resolveStrobe(rStrobe),
        .missStrobe   (rMiss)
    );

    // The SOF bit itself does not clear the recessive count while in IDLE.
    always_comb begin
        if (rBit == CAN_RECESSIVE) recInc = (recCnt == IDLE_CNT) ? recCnt : recCnt + 4'd1;
        else if (state == IDLE)    recInc = recCnt;
        else                       recInc = 4'd0;
    end

    always_comb begin
        stateNext    = state;
        recCntNext   = recCnt;
        runLenNext   = runLen;
        runValNext   = runVal;
        bitOutNext   = 1'b0;
        bitValidNext = 1'b0;
        sofNext      = 1'b0;
        stuffErrNext = 1'b0;
        if (rStrobe) begin
            recCntNext = recInc;
            unique case (state)
                WAIT_IDLE, ERROR: begin
                    if (recInc == IDLE_CNT) stateNext = IDLE;
                end
                IDLE: begin
                    if (rBit == CAN_DOMINANT) begin
                        bitValidNext = 1'b1;
                        sofNext      = 1'b1;
                        runValNext   = CAN_DOMINANT;
                        runLenNext   = 3'd1;
                        stateNext    = FRAME;
                    end
                end
                FRAME: begin
                    if (!enable) begin
                        bitValidNext = 1'b1;
                        bitOutNext   = rBit;
                        runLenNext   = 3'd0;
                        if (recInc == IDLE_CNT) stateNext = IDLE;
                    end else if (runLen == STUFF_CNT) begin
                        if (rBit == runVal) begin
                            stuffErrNext = 1'b1;
                            stateNext    = ERROR;
                        end else begin
                            runValNext = rBit;
                            runLenNext = 3'd1;
                        end
                    end else begin
                        bitValidNext = 1'b1;
                        bitOutNext   = rBit;
                        if (runLen != 3'd0 && rBit == runVal) begin
                            runLenNext = runLen + 3'd1;
                        end else begin
                            runValNext = rBit;
                            runLenNext = 3'd1;
                        end
                    end
                end
                default: stateNext = WAIT_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state      <= WAIT_IDLE;
            recCnt     <= 4'd0;
            runLen     <= 3'd0;
            runVal     <= CAN_RECESSIVE;
            bitOut     <= 1'b0;
            bitValid   <= 1'b0;
            sof        <= 1'b0;
            stuffErr   <= 1'b0;
            sampleMiss <= 1'b0;
            busIdle    <= 1'b0;
        end else begin
            state      <= stateNext;
            recCnt     <= recCntNext;
            runLen     <= runLenNext;
            runVal     <= runValNext;
            bitOut     <= bitOutNext;
            bitValid   <= bitValidNext;
            sof        <= sofNext;
            stuffErr   <= stuffErrNext;
            sampleMiss <= rMiss;
            busIdle    <= (stateNext == IDLE);
        end
    end

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Scoreboard bench for can_bit_destuffer: directed scenarios plus random
// bit streams checked against a bit-level behavioural model.
module tb_can_bit_destuffer;

    localparam int IDLE_BITS = 11;
    localparam int STUFF_LEN = 5;
    localparam int M_WAIT = 0, M_IDLE = 1, M_FRAME = 2, M_ERR = 3;

    logic clk = 1'b0;
    logic resetN = 1'b0, sampleIn = 1'b1, samplePulse = 1'b0, bitStrobe = 1'b0;
    logic multiSelect = 1'b0, enable = 1'b1;
    logic bitOut, bitValid, sof, stuffErr, sampleMiss, busIdle;

    can_bit_destuffer #(.IDLE_BITS(IDLE_BITS), .STUFF_LEN(STUFF_LEN)) dut (
        .clk(clk), .resetN(resetN), .sampleIn(sampleIn), .samplePulse(samplePulse),
        .bitStrobe(bitStrobe), .multiSelect(multiSelect), .enable(enable),
        .bitOut(bitOut), .bitValid(bitValid), .sof(sof), .stuffErr(stuffErr),
        .sampleMiss(sampleMiss), .busIdle(busIdle)
    );

    always #5 clk = ~clk;

    // {valid, bit (when valid), sof, stuffErr, sampleMiss, busIdle}
    typedef logic [5:0] evt_t;
    evt_t expQ[$];
    int errors = 0, checks = 0;

    int mSt, mRec, mRunLen;
    bit mRunVal, mPrev;

    task automatic check(input string name, input evt_t got, input evt_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        mSt = M_WAIT; mRec = 0; mRunLen = 0; mRunVal = 1'b1; mPrev = 1'b1;
    endtask

    // vals[i] is the i-th sample of the bit in arrival order; n samples total.
    task automatic modelBit(input logic [3:0] vals, input int n, input bit mode,
                            input bit en, output evt_t e);
        bit b, miss, v, s, se;
        int need, ones;
        need = mode ? 3 : 1;
        miss = (n < need);
        b = (n == 0) ? mPrev : vals[n-1];
        if (mode && n >= 3) begin
            ones = int'(vals[n-1]) + int'(vals[n-2]) + int'(vals[n-3]);
            b = (ones >= 2);
        end
        mPrev = b;
        if (b) mRec = (mRec + 1 > IDLE_BITS) ? IDLE_BITS : mRec + 1;
        else if (mSt != M_IDLE) mRec = 0;
        v = 0; s = 0; se = 0;
        case (mSt)
            M_WAIT, M_ERR: if (mRec == IDLE_BITS) mSt = M_IDLE;
            M_IDLE: if (!b) begin
                v = 1; s = 1; mRunVal = 0; mRunLen = 1; mSt = M_FRAME;
            end
            default: begin
                if (!en) begin
                    v = 1; mRunLen = 0;
                    if (mRec == IDLE_BITS) mSt = M_IDLE;
                end else if (mRunLen == STUFF_LEN) begin
                    if (b == mRunVal) begin se = 1; mSt = M_ERR; end
                    else begin mRunVal = b; mRunLen = 1; end
                end else begin
                    v = 1;
                    if (mRunLen > 0 && b == mRunVal) mRunLen++;
                    else begin mRunVal = b; mRunLen = 1; end
                end
            end
        endcase
        e = {v, v & b, s, se, miss, mSt == M_IDLE};
    endtask

    task automatic sendBit(input logic [3:0] vals, input int n, input bit mode,
                           input bit en, input bit onStrobe);
        evt_t e;
        int pre;
        multiSelect = mode;
        enable = en;
        pre = (onStrobe && n > 0) ? n - 1 : n;
        for (int i = 0; i < pre; i++) begin
            samplePulse = 1'b1; sampleIn = vals[i];
            tick();
            samplePulse = 1'b0;
            tick();
        end
        modelBit(vals, n, mode, en, e);
        expQ.push_back(e);
        bitStrobe = 1'b1;
        if (pre != n) begin samplePulse = 1'b1; sampleIn = vals[n-1]; end
        tick();
        bitStrobe = 1'b0; samplePulse = 1'b0;
        tick();
    endtask

    task automatic sendLevel(input bit lvl, input int count, input bit en);
        for (int i = 0; i < count; i++) sendBit({4{lvl}}, 1, 1'b0, en, 1'b0);
    endtask

    // Monitor: compares one scoreboard entry per resolved bit.
    logic strobeSeen = 1'b0;
    always @(posedge clk) strobeSeen <= bitStrobe && resetN;

    always @(negedge clk) begin
        if (resetN) begin
            if (strobeSeen) begin
                if (expQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_underflow got=output exp=none at %0t", $time);
                end else begin
                    check("bit_result", {bitValid, bitValid & bitOut, sof, stuffErr,
                                         sampleMiss, busIdle}, expQ.pop_front());
                end
            end else begin
                check("quiet_cycle", {bitValid, 1'b0, sof, stuffErr, sampleMiss, 1'b0}, 6'b0);
            end
        end
    end

    initial begin
        logic [3:0] vals;
        int n, lvl;
        bit mode, en;
        modelReset();
        repeat (3) tick();
        check("reset_outputs", {bitValid, bitOut, sof, stuffErr, sampleMiss, busIdle}, 6'b0);
        resetN = 1'b1;
        tick();

        // Idle detection, then a frame with one stuff bit.
        sendLevel(1'b1, IDLE_BITS, 1'b1);
        foreach (vals[i]) vals[i] = 1'b0;
        for (int i = 0; i < 5; i++) sendBit(4'b0000, 1, 1'b0, 1'b1, 1'b0);
        sendBit(4'b1111, 1, 1'b0, 1'b1, 1'b0);
        sendBit(4'b1111, 1, 1'b0, 1'b1, 1'b0);
        sendBit(4'b0000, 1, 1'b0, 1'b1, 1'b0);
        sendLevel(1'b1, 16, 1'b1);

        // Six dominant bits give a stuff error, then recover to idle.
        sendLevel(1'b0, 6, 1'b1);
        sendLevel(1'b1, IDLE_BITS, 1'b1);

        // Majority voting, sample misses, then unstuffed tail with enable low.
        sendBit(4'b0000, 1, 1'b0, 1'b1, 1'b0);
        sendBit(4'b0001, 3, 1'b1, 1'b1, 1'b0);
        sendBit(4'b0011, 3, 1'b1, 1'b1, 1'b1);
        sendBit(4'b0001, 1, 1'b1, 1'b1, 1'b0);
        sendBit(4'b0000, 0, 1'b0, 1'b1, 1'b0);
        sendBit(4'b0000, 1, 1'b0, 1'b1, 1'b0);
        sendLevel(1'b1, 12, 1'b0);

        // Reset mid-frame, then re-entry needs a full idle run.
        sendBit(4'b0000, 1, 1'b0, 1'b1, 1'b0);
        sendBit(4'b1111, 1, 1'b0, 1'b1, 1'b0);
        resetN = 1'b0;
        tick();
        check("midframe_reset", {bitValid, bitOut, sof, stuffErr, sampleMiss, busIdle}, 6'b0);
        modelReset();
        resetN = 1'b1;
        tick();
        sendLevel(1'b1, IDLE_BITS - 1, 1'b1);
        sendLevel(1'b0, 1, 1'b1);
        sendLevel(1'b1, IDLE_BITS, 1'b1);
        sendLevel(1'b0, 1, 1'b1);

        // Random bit streams with level runs, sample noise and misses.
        lvl = 0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) == 0) lvl = 1 - lvl;
            mode = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 4) != 0) n = mode ? 3 + $urandom_range(0, 1) : 1 + $urandom_range(0, 1);
            else n = $urandom_range(0, 2);
            for (int i = 0; i < 4; i++)
                vals[i] = ($urandom_range(0, 5) == 0) ? 1'(1 - lvl) : 1'(lvl);
            sendBit(vals, n, mode, en, 1'($urandom_range(0, 1)));
        end

        repeat (4) tick();
        check("scoreboard_drained", 6'(expQ.size()), 6'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
